rv_reverse_delay_line: RTL and testbench
========================================

Name: rv_reverse_delay_line

Overview:
- Chain of STAGES ready/valid reverse buffers (skid stages).
- Each stage registers the backward ready path; the forward valid and data paths pass combinationally while the stage is empty.
- Complements the forward-buffer delay line, which registers valid/data. Placing one in front of or behind it breaks long ready timing paths on streaming links.
- Storage capacity is STAGES words. There is zero forward latency when the chain is empty.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- STAGES, 5, number of reverse-buffer stages; legal range 1..16.

Ports:
- clock_port  in  1  single clock; all flops use the rising edge.
- reset_port  in  1  asynchronous, active-low reset.
- input_port_data  in  DATA_WIDTH  upstream payload.
- input_port_valid  in  1  upstream valid.
- input_port_ready  out  1  ready to upstream; driven by stage 0's registered state only.
- output_port_data  out  DATA_WIDTH  downstream payload.
- output_port_valid  out  1  downstream valid.
- output_port_ready  in  1  downstream ready.
- clear  in  1  synchronous flush of all stages.

Behaviour:
- Reset:
  - Asynchronous, active-low: reset_port=0 clears every stage's buf_valid and buf_data (data to 0) immediately, without waiting for a clock edge.
  - During reset: input_port_ready=1 and output_port_valid follows input_port_valid through the empty chain, unless clear=1.
  - Deassertion takes effect at the next rising edge.
- Stage i state: buf_valid_i (1 bit), buf_data_i (DATA_WIDTH). The stage's in-side is the previous stage's out-side; stage 0 faces the ports, stage STAGES-1 faces the output ports.
- Stage i combinational outputs:
  - in_ready_i = ~buf_valid_i.
  - out_valid_i = buf_valid_i | in_valid_i.
  - out_data_i = buf_valid_i ? buf_data_i : in_data_i.
- Stage i capture: if in_valid_i & in_ready_i & ~out_ready_i, then buf_valid_i<=1 and buf_data_i<=in_data_i.
- Stage i drain: if buf_valid_i & out_ready_i, then buf_valid_i<=0.
- Capture and drain are mutually exclusive by construction; holding otherwise.
- Ordering: words leave in arrival order. A full stage never accepts new input.
- Latency:
  - All stages empty: 0 cycles, output mirrors input in the same cycle.
  - k stages full: the buffered head is presented at the output.
- Ready latency: deasserting output_port_ready stalls input_port_ready only after every stage is full. That takes at least STAGES cycles of continuous input under a stalled output.
- Full condition: all buf_valid=1 gives input_port_ready=0. Empty condition: all buf_valid=0 gives a pure pass-through.
- Clear:
  - While clear=1: input_port_ready=0 and output_port_valid=0 (forced combinationally).
  - At the edge: all buf_valid<=0. buf_data is unchanged.
  - Buffered words are dropped. A word offered during clear is not transferred.
- Simultaneous events:
  - Clear takes priority over capture and drain.
  - Drain plus upstream offer on a full stage: the stage empties this edge; the offer is accepted next cycle.
- Reset mid-stream: all buffered words are lost; no partial words are produced.
- Data is don't-care when output_port_valid=0. The bench checks data only on valid&ready.

Optional Feature:
- Macro: RV_REVERSE_OCCUPANCY_EN.
- When defined:
  - Adds output port occupancy, width $clog2(STAGES+1), equal to the count of buf_valid bits.
  - The count is kept in a register that updates on the same edges as the stages. It resets to 0 and is cleared to 0 by clear.
  - It must equal popcount(buf_valid) every cycle; this is checked by assertion.
- When undefined: the port and counter are absent, and the behaviour is otherwise identical.

Test Plan:
- Empty pass-through: output_port_ready=1, drive 0x11,0x22,0x33 on consecutive cycles -> each appears on output_port_data in the same cycle; input_port_ready stays 1.
- Fill to full: output_port_ready=0, offer 0xA0..0xA5 continuously -> 0xA0..0xA4 accepted over 5 cycles, 0xA5 held. input_port_ready=0 from cycle 5 on. occupancy reaches 5 if RV_REVERSE_OCCUPANCY_EN.
- Drain order: from the full state, raise output_port_ready -> output order 0xA0,0xA1,0xA2,0xA3,0xA4,0xA5 with no loss or duplicates. occupancy returns to 0.
- Random backpressure: 1000 words, random valid/ready at 50% each -> output sequence equals input sequence; input_port_ready never 1 while all stages are full.
- Clear: with 3 words buffered, pulse clear for 1 cycle -> output_port_valid=0 and input_port_ready=0 that cycle. The next cycle is empty pass-through, and the 3 words never appear.
- Async reset: assert reset_port=0 mid-cycle with 4 words buffered -> buf_valid is cleared before the next edge. After release, new word 0x5A passes through with 0 latency.

Source files
------------

// File: rtl/rv_reverse_delay_line.sv
// rv_reverse_delay_line
//
// Chain of STAGES ready/valid reverse (skid) buffers. Each stage registers
// only the backward ready path. Valid and data pass straight through a stage
// while it is empty. A stage parks a word only when the word is offered and
// the downstream side is not ready. When every stage is empty the chain is a
// zero-latency wire. It holds at most STAGES words.
//
// Handshake: a word moves across any boundary on a rising edge where both
// valid and ready are high on that boundary. Valid never depends on ready.
// Ready toward upstream comes only from stage 0's registered state (and
// clear).
//
// Ports:
//   clock_port         rising-edge clock
//   reset_port         asynchronous active-low reset
//   input_port_data    upstream payload
//   input_port_valid   upstream valid
//   input_port_ready   ready to upstream (stage 0 empty, not clearing)
//   output_port_data   downstream payload
//   output_port_valid  downstream valid (forced low during clear)
//   output_port_ready  downstream ready
//   clear              synchronous flush; buffered words are dropped
//   occupancy          number of occupied stages (only with
//                      RV_REVERSE_OCCUPANCY_EN defined)
//
// Optional feature macro: RV_REVERSE_OCCUPANCY_EN
module rv_reverse_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 5
) (
  input  logic                  clock_port,
  input  logic                  reset_port,
  input  logic [DATA_WIDTH-1:0] input_port_data,
  input  logic                  input_port_valid,
  output logic                  input_port_ready,
  output logic [DATA_WIDTH-1:0] output_port_data,
  output logic                  output_port_valid,
  input  logic                  output_port_ready,
  input  logic                  clear
`ifdef RV_REVERSE_OCCUPANCY_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

  // Registered occupancy flags of all stages, index 0 nearest the input.
  logic [STAGES-1:0] buf_valid;
`ifdef RV_REVERSE_OCCUPANCY_EN
  logic [STAGES-1:0] buf_valid_next;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic                  bv_q;
    logic                  bv_d;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  capture;
    logic                  drain;

    // In-side: the ports for stage 0, otherwise the previous stage's out-side.
    if (i == 0) begin : g_head
      assign in_valid = input_port_valid;
      assign in_data  = input_port_data;
    end else begin : g_link
      assign in_valid = g_stage[i-1].out_valid;
      assign in_data  = g_stage[i-1].out_data;
    end

    // Out-side ready: the next stage's registered emptiness, so the ready path
    // never ripples combinationally through the chain.
    if (i == STAGES - 1) begin : g_tail
      assign out_ready = output_port_ready;
    end else begin : g_mid
      assign out_ready = ~buf_valid[i+1];
    end

    assign out_valid = bv_q | in_valid;
    assign out_data  = bv_q ? buf_data : in_data;

    // in_ready of this stage is ~bv_q, so capture needs an empty stage and
    // drain needs a full one: the two can never coincide.
    assign capture = in_valid & ~bv_q & ~out_ready;
    assign drain   = bv_q & out_ready;

    always_comb begin
      bv_d = bv_q;
      if (clear) begin
        bv_d = 1'b0;
      end else if (capture) begin
        bv_d = 1'b1;
      end else if (drain) begin
        bv_d = 1'b0;
      end
    end

    always_ff @(posedge clock_port or negedge reset_port) begin
      if (!reset_port) begin
        bv_q     <= 1'b0;
        buf_data <= '0;
      end else begin
        bv_q <= bv_d;
        if (!clear && capture) begin
          buf_data <= in_data;
        end
      end
    end

    assign buf_valid[i] = bv_q;
`ifdef RV_REVERSE_OCCUPANCY_EN
    assign buf_valid_next[i] = bv_d;
`endif
  end

  assign input_port_ready  = ~buf_valid[0] & ~clear;
  assign output_port_valid = g_stage[STAGES-1].out_valid & ~clear;
  assign output_port_data  = g_stage[STAGES-1].out_data;

`ifdef RV_REVERSE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(STAGES + 1);

  function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int k = 0; k < STAGES; k++) begin
      c = c + OCC_W'(v[k]);
    end
    return c;
  endfunction

  // Tracks the flags' next state so it moves on exactly the same edges;
  // clear already zeroes every next flag.
  always_ff @(posedge clock_port or negedge reset_port) begin
    if (!reset_port) begin
      occupancy <= '0;
    end else begin
      occupancy <= popcount(buf_valid_next);
    end
  end

  occupancy_matches_flags : assert property (
    @(posedge clock_port) disable iff (!reset_port)
    occupancy == popcount(buf_valid)
  );
`endif

endmodule

// File: tb/tb_rv_reverse_delay_line.sv
// Directed bench for rv_reverse_delay_line (DATA_WIDTH=8, STAGES=5), plus a
// randomized backpressure run scored against an expected queue. Inputs
// change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_rv_reverse_delay_line;
  localparam int W = 8;
  localparam int N = 5;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         clear;
`ifdef RV_REVERSE_OCCUPANCY_EN
  logic [2:0]   occ;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  rv_reverse_delay_line #(.DATA_WIDTH(W), .STAGES(N)) dut (
    .clock_port        (clk),
    .reset_port        (rst_n),
    .input_port_data   (in_data),
    .input_port_valid  (in_valid),
    .input_port_ready  (in_ready),
    .output_port_data  (out_data),
    .output_port_valid (out_valid),
    .output_port_ready (out_ready),
    .clear             (clear)
`ifdef RV_REVERSE_OCCUPANCY_EN
    ,
    .occupancy         (occ)
`endif
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic offer(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
  endtask

  logic [W-1:0] pt [3];
  logic [W-1:0] cur_word;
  logic [W-1:0] head;
  int n_sent;
  int n_recv;
  int level;
  int cyc;

  initial begin
    pt[0] = 8'h11; pt[1] = 8'h22; pt[2] = 8'h33;

    // Reset state: empty chain passes valid/data through, ready high.
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0;
    offer(8'h77);
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd1);
    check("rst_out_data", 32'(out_data), 32'h77);
`ifdef RV_REVERSE_OCCUPANCY_EN
    check("rst_occ", 32'(occ), 32'd0);
`endif
    clear = 1'b1;
    #1;
    check("rst_clear_valid", 32'(out_valid), 32'd0);
    check("rst_clear_ready", 32'(in_ready), 32'd0);
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Empty pass-through.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      offer(pt[k]);
      sample();
      check("pt_valid", 32'(out_valid), 32'd1);
      check("pt_data", 32'(out_data), 32'(pt[k]));
      check("pt_ready", 32'(in_ready), 32'd1);
      next_cycle();
    end
    in_valid = 1'b0;

    // Fill to full with the output stalled: head stays 0xA0.
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      offer(8'hA0 + 8'(k));
      sample();
      check("fill_ready", 32'(in_ready), 32'd1);
      check("fill_valid", 32'(out_valid), 32'd1);
      check("fill_head", 32'(out_data), 32'hA0);
      next_cycle();
    end
    offer(8'hA5);
    for (int k = 0; k < 2; k++) begin
      sample();
      check("full_ready", 32'(in_ready), 32'd0);
      check("full_head", 32'(out_data), 32'hA0);
`ifdef RV_REVERSE_OCCUPANCY_EN
      check("full_occ", 32'(occ), 32'd5);
`endif
      next_cycle();
    end

    // Drain in order; 0xA5 is taken once stage 0 has emptied.
    out_ready = 1'b1;
    for (int k = 0; k <= N; k++) begin
      sample();
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_data", 32'(out_data), 32'hA0 + 32'(k));
      check("drain_ready", 32'(in_ready), (k == N) ? 32'd1 : 32'd0);
      next_cycle();
    end
    in_valid = 1'b0;
    sample();
    check("drain_empty", 32'(out_valid), 32'd0);
`ifdef RV_REVERSE_OCCUPANCY_EN
    check("drain_occ", 32'(occ), 32'd0);
`endif
    next_cycle();

    // Clear with three words buffered.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(8'hC1 + 8'(k));
      next_cycle();
    end
    in_valid = 1'b0;
    clear = 1'b1;
    sample();
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_ready", 32'(in_ready), 32'd0);
    next_cycle();
    clear = 1'b0; out_ready = 1'b1;
    offer(8'h5E);
    sample();
    check("postclr_valid", 32'(out_valid), 32'd1);
    check("postclr_data", 32'(out_data), 32'h5E);
    check("postclr_ready", 32'(in_ready), 32'd1);
`ifdef RV_REVERSE_OCCUPANCY_EN
    check("postclr_occ", 32'(occ), 32'd0);
`endif
    next_cycle();
    in_valid = 1'b0;
    sample();
    check("postclr_gone", 32'(out_valid), 32'd0);
    next_cycle();

    // Asynchronous reset with four words buffered.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      offer(8'hD1 + 8'(k));
      next_cycle();
    end
    in_valid = 1'b0;
    sample();
    check("pre_arst_valid", 32'(out_valid), 32'd1);
    check("pre_arst_head", 32'(out_data), 32'hD1);
`ifdef RV_REVERSE_OCCUPANCY_EN
    check("pre_arst_occ", 32'(occ), 32'd4);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
`ifdef RV_REVERSE_OCCUPANCY_EN
    check("arst_occ", 32'(occ), 32'd0);
`endif
    offer(8'h99);
    #1;
    check("arst_pt_data", 32'(out_data), 32'h99);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    out_ready = 1'b1;
    offer(8'h5A);
    sample();
    check("post_arst_valid", 32'(out_valid), 32'd1);
    check("post_arst_data", 32'(out_data), 32'h5A);
    check("post_arst_ready", 32'(in_ready), 32'd1);
    next_cycle();
    in_valid = 1'b0;

    // Random backpressure, 1000 words.
    n_sent = 0; n_recv = 0; level = 0; cyc = 0;
    cur_word = 8'($urandom_range(0, 255));
    while (n_recv < 1000 && cyc < 20000) begin
      in_valid  = (n_sent < 1000) && ($urandom_range(0, 1) == 1);
      in_data   = cur_word;
      out_ready = ($urandom_range(0, 1) == 1);
      sample();
      if (level == N) check("rand_full_ready", 32'(in_ready), 32'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_word);
        n_sent++;
        level++;
        cur_word = 8'($urandom_range(0, 255));
      end
      if (out_valid && out_ready) begin
        check("rand_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          head = exp_q.pop_front();
          check("rand_data", 32'(out_data), 32'(head));
        end
        n_recv++;
        level--;
      end
      cyc++;
      next_cycle();
    end
    in_valid = 1'b0;
    check("rand_recv_count", 32'(n_recv), 32'd1000);
    check("rand_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
